// File: rtl/ddr4_reset_n_seq.sv
// DDR4 RESET_N power-up sequencer: holds RESET_N low, releases it, then waits
// before permitting CKE. Drives a 4:1 geared IOD lane with replicated bits.
module ddr4_reset_n_seq #(
    parameter int T_RESET_LOW = 33334,
    parameter int T_CKE_WAIT  = 83334
) (
    input  logic       FAB_CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic       REINIT,
    input  logic       DELAY_LINE_OUT_OF_RANGE,
    output logic [3:0] TX_DATA,
    output logic [3:0] OE_DATA,
    output logic       DELAY_LINE_MOVE,
    output logic       DELAY_LINE_DIRECTION,
    output logic       DELAY_LINE_LOAD,
    output logic       ODT_EN,
    output logic       CKE_EN,
    output logic       INIT_DONE,
    output logic       DL_ERR
);

    localparam int NUM_LANES = 4;
    localparam logic [23:0] RL_LAST = 24'(T_RESET_LOW - 1);
    localparam logic [23:0] CW_LAST = 24'(T_CKE_WAIT - 1);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_ASSERT  = 2'd1,
        S_RELEASE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t      state;
    logic [23:0] cnt;
    logic        tx_hi;
    logic        load_seen;

    // Outputs are updated together with the state so they line up with it.
    always_ff @(posedge FAB_CLK) begin
        if (!RST_N) begin
            state     <= S_HOLD;
            cnt       <= '0;
            tx_hi     <= 1'b0;
            CKE_EN    <= 1'b0;
            INIT_DONE <= 1'b0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (START) begin
                        state <= S_ASSERT;
                        cnt   <= '0;
                    end
                end
                S_ASSERT: begin
                    if (cnt == RL_LAST) begin
                        state <= S_RELEASE;
                        cnt   <= '0;
                        tx_hi <= 1'b1;
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end
                S_RELEASE: begin
                    if (cnt == CW_LAST) begin
                        state     <= S_DONE;
                        cnt       <= '0;
                        CKE_EN    <= 1'b1;
                        INIT_DONE <= 1'b1;
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end
                S_DONE: begin
                    // REINIT takes priority; START is meaningless here.
                    if (REINIT) begin
                        state     <= S_ASSERT;
                        cnt       <= '0;
                        tx_hi     <= 1'b0;
                        CKE_EN    <= 1'b0;
                        INIT_DONE <= 1'b0;
                    end
                end
                default: begin
                    state <= S_HOLD;
                    cnt   <= '0;
                    tx_hi <= 1'b0;
                end
            endcase
        end
    end

    // One-shot delay-line load on the first cycle out of reset.
    always_ff @(posedge FAB_CLK) begin
        if (!RST_N) begin
            DELAY_LINE_LOAD <= 1'b0;
            load_seen       <= 1'b0;
        end else begin
            DELAY_LINE_LOAD <= ~load_seen;
            load_seen       <= 1'b1;
        end
    end

    always_ff @(posedge FAB_CLK) begin
        if (!RST_N)
            DL_ERR <= 1'b0;
        else if (DELAY_LINE_OUT_OF_RANGE)
            DL_ERR <= 1'b1;
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign TX_DATA[i] = tx_hi;
        assign OE_DATA[i] = 1'b1;
    end

    assign ODT_EN               = 1'b0;
    assign DELAY_LINE_MOVE      = 1'b0;
    assign DELAY_LINE_DIRECTION = 1'b0;

endmodule

// File: tb/tb_ddr4_reset_n_seq.sv
// Bench for ddr4_reset_n_seq: directed timing pins plus randomized traffic
// checked every cycle against a time-since-start reference model.
module tb_ddr4_reset_n_seq;

    localparam int TRL = 4;
    localparam int TCW = 6;

    logic       FAB_CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       START = 1'b0;
    logic       REINIT = 1'b0;
    logic       DELAY_LINE_OUT_OF_RANGE = 1'b0;
    logic [3:0] TX_DATA, OE_DATA;
    logic       DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD;
    logic       ODT_EN, CKE_EN, INIT_DONE, DL_ERR;

    int errors = 0;
    int checks = 0;

    always #5 FAB_CLK = ~FAB_CLK;

    ddr4_reset_n_seq #(.T_RESET_LOW(TRL), .T_CKE_WAIT(TCW)) dut (
        .FAB_CLK(FAB_CLK), .RST_N(RST_N), .START(START), .REINIT(REINIT),
        .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE),
        .TX_DATA(TX_DATA), .OE_DATA(OE_DATA),
        .DELAY_LINE_MOVE(DELAY_LINE_MOVE), .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION),
        .DELAY_LINE_LOAD(DELAY_LINE_LOAD), .ODT_EN(ODT_EN),
        .CKE_EN(CKE_EN), .INIT_DONE(INIT_DONE), .DL_ERR(DL_ERR)
    );

    // Reference model: a sequence is "active" from the cycle it starts; the
    // pin and done flags follow purely from elapsed cycles since that start.
    int cyc = 0;
    int seq_start = 0;
    bit active = 0;
    bit known = 0;
    bit load_seen = 0;
    bit load_exp = 0;
    bit err_exp = 0;

    function automatic bit m_tx_hi();
        return active && (cyc - seq_start >= TRL);
    endfunction

    function automatic bit m_done();
        return active && (cyc - seq_start >= TRL + TCW);
    endfunction

    always @(posedge FAB_CLK) begin
        if (!RST_N) begin
            active = 0; load_seen = 0; load_exp = 0; err_exp = 0; known = 1;
        end else begin
            load_exp = !load_seen;
            load_seen = 1;
            if (DELAY_LINE_OUT_OF_RANGE) err_exp = 1;
            if (!active) begin
                if (START) begin active = 1; seq_start = cyc + 1; end
            end else if (m_done() && REINIT) begin
                seq_start = cyc + 1;
            end
        end
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge FAB_CLK) begin
        if (known) begin
            check("tx_data",   32'(TX_DATA), m_tx_hi() ? 32'hF : 32'h0);
            check("oe_data",   32'(OE_DATA), 32'hF);
            check("cke_en",    32'(CKE_EN), 32'(m_done()));
            check("init_done", 32'(INIT_DONE), 32'(m_done()));
            check("dl_load",   32'(DELAY_LINE_LOAD), 32'(load_exp));
            check("dl_err",    32'(DL_ERR), 32'(err_exp));
            check("statics",   {29'd0, ODT_EN, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION}, 32'd0);
        end
    end

    task automatic tick();
        @(negedge FAB_CLK);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_tx", 32'(TX_DATA), 32'h0);
        check("rst_oe", 32'(OE_DATA), 32'hF);
        check("rst_load", 32'(DELAY_LINE_LOAD), 32'h0);
        check("rst_done", 32'(INIT_DONE), 32'h0);

        RST_N = 1'b1;
        tick();
        check("load_pulse", 32'(DELAY_LINE_LOAD), 32'h1);
        tick();
        check("load_off", 32'(DELAY_LINE_LOAD), 32'h0);
        repeat (10) tick();
        check("idle_tx", 32'(TX_DATA), 32'h0);
        check("idle_done", 32'(INIT_DONE), 32'h0);

        // Power-up sequence with REINIT/START noise during ASSERT and RELEASE.
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 4)  check("seq_tx_n4", 32'(TX_DATA), 32'h0);
            if (k == 5)  check("seq_tx_n5", 32'(TX_DATA), 32'hF);
            if (k == 10) check("seq_done_n10", 32'(INIT_DONE), 32'h0);
            if (k == 11) check("seq_done_n11", {CKE_EN, INIT_DONE}, 32'h3);
            REINIT = (k == 2 || k == 7);
            START  = (k == 3);
            tick();
        end

        // REINIT from DONE, with START also high: REINIT must win.
        check("pre_dl_err", 32'(DL_ERR), 32'h0);
        REINIT = 1'b1;
        START  = 1'b1;
        tick();
        REINIT = 1'b0;
        START  = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 1)  check("re_n1", {TX_DATA, INIT_DONE}, 32'h0);
            if (k == 4)  check("re_tx_n4", 32'(TX_DATA), 32'h0);
            if (k == 5)  check("re_tx_n5", 32'(TX_DATA), 32'hF);
            if (k == 10) check("re_done_n10", 32'(INIT_DONE), 32'h0);
            if (k == 11) check("re_done_n11", 32'(INIT_DONE), 32'h1);
            tick();
        end

        // Sticky delay-line error survives REINIT.
        DELAY_LINE_OUT_OF_RANGE = 1'b1;
        tick();
        DELAY_LINE_OUT_OF_RANGE = 1'b0;
        check("dl_err_set", 32'(DL_ERR), 32'h1);
        REINIT = 1'b1;
        tick();
        REINIT = 1'b0;
        repeat (12) tick();
        check("dl_err_sticky", 32'(DL_ERR), 32'h1);

        // Reset on the second RELEASE cycle aborts the sequence.
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        check("dl_err_clr", 32'(DL_ERR), 32'h0);
        tick();
        START = 1'b1;
        tick();
        START = 1'b0;
        repeat (5) tick();
        check("rel2_tx", 32'(TX_DATA), 32'hF);
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        check("abort_tx", {TX_DATA, CKE_EN}, 32'h0);
        repeat (15) tick();
        check("abort_hold", {TX_DATA, INIT_DONE}, 32'h0);

        // Randomized traffic, checked by the per-cycle compare process.
        repeat (3000) begin
            RST_N  = ($urandom_range(0, 199) != 0);
            START  = ($urandom_range(0, 19) == 0);
            REINIT = ($urandom_range(0, 7) == 0);
            DELAY_LINE_OUT_OF_RANGE = ($urandom_range(0, 99) == 0);
            tick();
        end
        RST_N = 1'b1; START = 1'b0; REINIT = 1'b0; DELAY_LINE_OUT_OF_RANGE = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddr4_reset_n_seq.md
DDR4_RESET_N_SEQ -- requirements
Module: ddr4_reset_n_seq

Interface
REQ-001 SHALL have parameter T_RESET_LOW, default 33334, FAB_CLK cycles RESET_N is held low (200 us at 166.667 MHz); legal range 1..2^24-1.
REQ-002 SHALL have parameter T_CKE_WAIT, default 83334, FAB_CLK cycles from RESET_N release to CKE enable (500 us); legal range 1..2^24-1.
REQ-003 FAB_CLK  in  1  fabric clock, 4:1 gearing to the RESET_N lane; the only clock.
REQ-004 RST_N  in  1  reset, synchronous, active-low.
REQ-005 START  in  1  level; begin the power-up reset sequence.
REQ-006 REINIT  in  1  single-cycle pulse; re-run the sequence from DONE.
REQ-007 DELAY_LINE_OUT_OF_RANGE  in  1  status from the RESET_N IOD delay line.
REQ-008 TX_DATA  out  4  serialized RESET_N bits to the IOD; all bits equal.
REQ-009 OE_DATA  out  4  output-enable bits to the IOD.
REQ-010 DELAY_LINE_MOVE, DELAY_LINE_DIRECTION  out  1 each  delay line control.
REQ-011 DELAY_LINE_LOAD  out  1  delay line load strobe.
REQ-012 ODT_EN  out  1  IOD ODT enable.
REQ-013 CKE_EN  out  1  permits the CKE lane to drive high.
REQ-014 INIT_DONE  out  1  sequence complete.
REQ-015 DL_ERR  out  1  sticky delay-line out-of-range flag.

Function
REQ-016 SHALL implement four states: HOLD, ASSERT, RELEASE, DONE.
REQ-017 HOLD: TX_DATA=4'h0; START=1 -> ASSERT next cycle, counter cleared.
REQ-018 ASSERT: TX_DATA=4'h0; exactly T_RESET_LOW cycles, then -> RELEASE.
REQ-019 RELEASE: TX_DATA=4'hF; exactly T_CKE_WAIT cycles, then -> DONE.
REQ-020 DONE: TX_DATA=4'hF, CKE_EN=1, INIT_DONE=1; REINIT=1 -> ASSERT next cycle, counter cleared, CKE_EN and INIT_DONE cleared the same cycle TX_DATA returns to 4'h0.
REQ-021 REINIT SHALL be ignored in HOLD, ASSERT and RELEASE; START SHALL be ignored outside HOLD.
REQ-022 The single 24-bit counter SHALL count up from 0 and be compared against (parameter-1); no wrap-around occurs within legal parameter range.
REQ-023 CKE_EN and INIT_DONE SHALL be registered and asserted on the first DONE cycle, 0 in every other state.
REQ-024 OE_DATA SHALL be 4'hF in all states, including during reset.
REQ-025 ODT_EN, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION SHALL be constant 0.
REQ-026 DELAY_LINE_LOAD SHALL pulse high for exactly one cycle: the first cycle after RST_N is sampled high following reset.
REQ-027 DL_ERR SHALL set one cycle after DELAY_LINE_OUT_OF_RANGE is sampled 1 and hold until reset.
REQ-028 START and REINIT asserted together in DONE: REINIT wins (-> ASSERT).

Reset
REQ-029 RST_N=0 at any rising FAB_CLK edge SHALL force, next cycle: state HOLD, counter 0, TX_DATA=4'h0, OE_DATA=4'hF, CKE_EN=0, INIT_DONE=0, DELAY_LINE_LOAD=0, DL_ERR=0.
REQ-030 Reset mid-ASSERT/RELEASE/DONE SHALL abort the sequence; RESET_N pin goes low the cycle after reset is sampled; a new START is required.

Verification (T_RESET_LOW=4, T_CKE_WAIT=6)
REQ-031 Reset release, START=0 -> DELAY_LINE_LOAD high exactly 1 cycle, TX_DATA stays 4'h0, INIT_DONE=0 indefinitely.
REQ-032 START=1 at cycle N -> TX_DATA=4'h0 cycles N+1..N+4, 4'hF from N+5, CKE_EN=INIT_DONE=1 from N+11.
REQ-033 REINIT pulse in DONE -> TX_DATA=4'h0 and INIT_DONE=0 next cycle, low for exactly 4 cycles, INIT_DONE back after 6 further cycles.
REQ-034 REINIT pulses during ASSERT and RELEASE -> no change to cycle timing of REQ-032.
REQ-035 RST_N=0 on cycle 2 of RELEASE -> TX_DATA=4'h0, CKE_EN=0 next cycle; HOLD held until START.
REQ-036 DELAY_LINE_OUT_OF_RANGE one-cycle pulse -> DL_ERR=1 next cycle, stays 1 through REINIT, cleared only by RST_N=0.
